fetch_branch_unit: RTL and testbench
====================================

FETCH_BRANCH_UNIT -- requirements
Module: fetch_branch_unit

Interface
REQ-001 The block SHALL have one parameter: STACK_DEPTH, default 8, meaning the number of return-address entries (power of two, 2..16).
REQ-002 The block SHALL have the following ports, one per line, in this order:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high.
- CounterValue  in  16 signed  current program counter value.
- InstrAddr  out  16  instruction memory read address.
- InstrReq  out  1  instruction read request.
- InstrValid  in  1  InstrData valid.
- InstrData  in  16  fetched instruction word.
- Zero  in  1  ALU zero flag.
- Stall  in  1  execute stage not ready.
- IssueValid  out  1  IssueInstr valid, single-cycle pulse.
- IssueInstr  out  16  instruction forwarded to execute.
- LoadValue  out  16 signed  program counter load value.
- LoadEnable  out  1  program counter load.
- Offset  out  9 signed  program counter relative offset.
- OffsetEnable  out  1  program counter offset add.
- StackError  out  1  sticky return-stack overflow/underflow flag.

Function
REQ-003 The FSM SHALL have states S_FETCH, S_WAIT and S_ADVANCE: S_FETCH->S_WAIT always; S_WAIT->S_ADVANCE when InstrValid=1; S_ADVANCE->S_FETCH when Stall=0, else stay.
REQ-004 The program counter increments whenever no enable is asserted, so in S_FETCH, S_WAIT and stalled S_ADVANCE the block SHALL hold it with LoadEnable=1, LoadValue=CounterValue, OffsetEnable=0.
REQ-005 In S_FETCH the block SHALL drive InstrReq=1 and InstrAddr=CounterValue; in all other states InstrReq=0 and InstrAddr=CounterValue.
REQ-006 On the S_WAIT->S_ADVANCE transition the block SHALL register InstrData; InstrValid outside S_WAIT SHALL be ignored.
REQ-007 Opcode is instr[15:12]: 4'hC JMP, 4'hD BRZ, 4'hE CALL, 4'hF RET; all other values are ordinary instructions.
REQ-008 In unstalled S_ADVANCE, ordinary instruction: IssueValid=1, IssueInstr=registered word, no enables (PC +1).
REQ-009 JMP: LoadEnable=1, LoadValue={4'b0000, instr[11:0]}.
REQ-010 BRZ: if Zero=1 (sampled this cycle), OffsetEnable=1, Offset=instr[8:0], target = instruction address + sign-extended offset, modulo 2^16; if Zero=0, no enables (PC +1).
REQ-011 CALL: push CounterValue+1 (modulo 2^16); LoadEnable=1, LoadValue={4'b0000, instr[11:0]}.
REQ-012 RET: pop; LoadEnable=1, LoadValue=popped entry.
REQ-013 Control opcodes (JMP, BRZ, CALL, RET) SHALL NOT assert IssueValid.
REQ-014 CALL with a full stack SHALL set StackError, discard the push and still perform the jump.
REQ-015 RET with an empty stack SHALL set StackError, leave the stack unchanged and assert no enables (PC +1).
REQ-016 Stalled S_ADVANCE SHALL NOT issue, push, pop or change StackError; the action occurs in the first unstalled S_ADVANCE cycle.
REQ-017 LoadEnable and OffsetEnable SHALL never be asserted in the same cycle.
REQ-018 IssueInstr SHALL equal the registered instruction word whenever IssueValid=0.
REQ-019 Each instruction SHALL take at least 3 cycles (S_FETCH, S_WAIT, S_ADVANCE).

Reset
REQ-020 Reset SHALL force state S_FETCH, stack pointer 0, StackError 0 and the registered instruction to 16'h0000.
REQ-021 Reset asserted during S_WAIT SHALL abandon the fetch; a late InstrValid after reset is released SHALL be ignored until the next S_WAIT.
REQ-022 StackError SHALL clear only on Reset.

Structure
REQ-023 The shared package misc_pkg SHALL hold the opcode enum, the FSM state enum, WORD_W=16 and OFFSET_W=9.
REQ-024 The return stack SHALL be a separate sub-module, return_stack:
- push/pop ports, data in/out, full/empty flags.
- one-cycle update.
- push and pop never asserted together.

Verification
REQ-025 PC=0x0010, InstrData=0x1234 after 2 wait cycles -> IssueValid pulse with 0x1234, no enables in S_ADVANCE, PC=0x0011, LoadEnable=1 in every hold cycle.
REQ-026 Branch on Zero at PC=0x0020:
- instr 0xD1FE with Zero=1 -> OffsetEnable=1, Offset=-2, next PC 0x001E.
- same instr with Zero=0 -> next PC 0x0021.
REQ-027 CALL/RET round trip:
- CALL 0xE100 at PC=0x0005 -> LoadValue 0x0100, stack top 0x0006.
- then RET 0xF000 -> LoadValue 0x0006, stack empty.
REQ-028 Stack limits:
- 9 nested CALLs with STACK_DEPTH=8 -> StackError=1 on the 9th, jump still taken.
- RET with empty stack after Reset -> StackError=1, PC +1.
REQ-029 Stall=1 for 3 cycles in S_ADVANCE with an ordinary instruction -> PC held, no IssueValid until Stall=0, then exactly one pulse.
REQ-030 Reset asserted in S_WAIT, InstrValid arriving 1 cycle after release -> ignored; a new InstrReq is raised in S_FETCH.

Source files
------------

// File: rtl/misc_pkg.sv
// Shared definitions for the fetch/branch unit: widths, opcodes, FSM states.
package misc_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned OFFSET_W = 9;

    typedef enum logic [3:0] {
        OP_JMP  = 4'hC,
        OP_BRZ  = 4'hD,
        OP_CALL = 4'hE,
        OP_RET  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ADVANCE
    } state_e;

    // Absolute targets live in the low 4K words.
    function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] instr);
        return {4'b0000, instr[11:0]};
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push and pop update in one cycle, top is read combinationally.
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_sp == PTR_W'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_rd_idx  = w_wr_idx - IDX_W'(1);
    assign o_data    = r_mem[w_rd_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + PTR_W'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - PTR_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch sequencer with jump/branch/call/return handling; steers an external PC that
// increments by default and is held via LoadEnable while an instruction is in flight.
module fetch_branch_unit
    import misc_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic signed [WORD_W-1:0]   CounterValue,
    output logic        [WORD_W-1:0]   InstrAddr,
    output logic                       InstrReq,
    input  logic                       InstrValid,
    input  logic        [WORD_W-1:0]   InstrData,
    input  logic                       Zero,
    input  logic                       Stall,
    output logic                       IssueValid,
    output logic        [WORD_W-1:0]   IssueInstr,
    output logic signed [WORD_W-1:0]   LoadValue,
    output logic                       LoadEnable,
    output logic signed [OFFSET_W-1:0] Offset,
    output logic                       OffsetEnable,
    output logic                       StackError
);

    state_e            r_state;
    state_e            w_next;
    logic [WORD_W-1:0] r_instr;
    logic              r_stack_err;
    logic [3:0]        w_opcode;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;
    logic [WORD_W-1:0] w_push_data;
    logic [WORD_W-1:0] w_stack_top;
    logic              w_stack_full;
    logic              w_stack_empty;

    assign w_opcode    = r_instr[15:12];
    assign w_push_data = CounterValue + 16'sd1;
    assign InstrAddr   = CounterValue;
    assign IssueInstr  = r_instr;
    assign StackError  = r_stack_err;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (WORD_W)
    ) u_return_stack (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_stack_top),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty)
    );

    always_comb begin
        w_next       = r_state;
        InstrReq     = 1'b0;
        LoadEnable   = 1'b0;
        LoadValue    = CounterValue;
        OffsetEnable = 1'b0;
        Offset       = r_instr[OFFSET_W-1:0];
        IssueValid   = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            S_FETCH: begin
                InstrReq   = 1'b1;
                LoadEnable = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                LoadEnable = 1'b1;
                if (InstrValid) begin
                    w_next = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (Stall) begin
                    LoadEnable = 1'b1;
                end else begin
                    w_next = S_FETCH;
                    case (w_opcode)
                        OP_JMP: begin
                            LoadEnable = 1'b1;
                            LoadValue  = jump_target(r_instr);
                        end
                        OP_BRZ: begin
                            OffsetEnable = Zero;
                        end
                        OP_CALL: begin
                            // Overflow drops the return address but the jump still happens.
                            LoadEnable = 1'b1;
                            LoadValue  = jump_target(r_instr);
                            if (w_stack_full) begin
                                w_err_set = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (w_stack_empty) begin
                                w_err_set = 1'b1;
                            end else begin
                                w_pop      = 1'b1;
                                LoadEnable = 1'b1;
                                LoadValue  = w_stack_top;
                            end
                        end
                        default: begin
                            IssueValid = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_FETCH;
            r_instr     <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && InstrValid) begin
                r_instr <= InstrData;
            end
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit: vector table plus stall, reset and stack-limit sequences.
module tb_fetch_branch_unit;

    logic               Clock = 1'b0;
    logic               Reset;
    logic signed [15:0] pc;
    logic        [15:0] InstrAddr;
    logic               InstrReq;
    logic               InstrValid;
    logic        [15:0] InstrData;
    logic               Zero;
    logic               Stall;
    logic               IssueValid;
    logic        [15:0] IssueInstr;
    logic signed [15:0] LoadValue;
    logic               LoadEnable;
    logic signed [8:0]  Offset;
    logic               OffsetEnable;
    logic               StackError;

    logic               pc_set_en;
    logic        [15:0] pc_set_val;
    logic signed [15:0] off_ext;

    int n_checks = 0;
    int n_fail   = 0;

    logic        cap_issue;
    logic [15:0] cap_issue_instr;
    logic        cap_ld_en;
    logic [15:0] cap_ld_val;
    logic        cap_off_en;
    logic [8:0]  cap_off;
    logic [15:0] cap_next_pc;

    fetch_branch_unit #(
        .STACK_DEPTH (8)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .CounterValue (pc),
        .InstrAddr    (InstrAddr),
        .InstrReq     (InstrReq),
        .InstrValid   (InstrValid),
        .InstrData    (InstrData),
        .Zero         (Zero),
        .Stall        (Stall),
        .IssueValid   (IssueValid),
        .IssueInstr   (IssueInstr),
        .LoadValue    (LoadValue),
        .LoadEnable   (LoadEnable),
        .Offset       (Offset),
        .OffsetEnable (OffsetEnable),
        .StackError   (StackError)
    );

    always #5 Clock = ~Clock;

    // External program counter: default increment, load wins over offset.
    assign off_ext = Offset;
    always @(posedge Clock) begin
        if (pc_set_en)         pc <= pc_set_val;
        else if (LoadEnable)   pc <= LoadValue;
        else if (OffsetEnable) pc <= pc + off_ext;
        else                   pc <= pc + 16'sd1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic hold_chk(input string tag);
        chk({tag, " hold_le"}, {15'd0, LoadEnable}, 16'd1);
        chk({tag, " hold_lv"}, LoadValue, pc);
        chk({tag, " hold_oe"}, {15'd0, OffsetEnable}, 16'd0);
        chk({tag, " hold_iv"}, {15'd0, IssueValid}, 16'd0);
        chk({tag, " addr"}, InstrAddr, pc);
    endtask

    // Starts at a negedge in S_FETCH, ends at the negedge after S_ADVANCE (back in S_FETCH).
    task automatic run_instr(input logic do_set, input logic [15:0] pc0, input logic [15:0] instr,
                             input logic zero, input int wait_c, input int stall_c,
                             input string tag);
        chk({tag, " req"}, {15'd0, InstrReq}, 16'd1);
        if (do_set) begin
            pc_set_val = pc0;
            pc_set_en  = 1'b1;
        end
        @(negedge Clock);
        pc_set_en = 1'b0;
        #1;
        hold_chk(tag);
        chk({tag, " req_wait"}, {15'd0, InstrReq}, 16'd0);
        for (int i = 0; i < wait_c; i++) begin
            @(negedge Clock);
            #1;
            hold_chk(tag);
        end
        InstrValid = 1'b1;
        InstrData  = instr;
        Zero       = zero;
        Stall      = (stall_c > 0);
        @(negedge Clock);
        InstrValid = 1'b0;
        InstrData  = 16'hBEEF;
        for (int i = 0; i < stall_c; i++) begin
            #1;
            hold_chk({tag, " stall"});
            @(negedge Clock);
        end
        Stall = 1'b0;
        #1;
        cap_issue       = IssueValid;
        cap_issue_instr = IssueInstr;
        cap_ld_en       = LoadEnable;
        cap_ld_val      = LoadValue;
        cap_off_en      = OffsetEnable;
        cap_off         = Offset;
        chk({tag, " issue_instr"}, IssueInstr, instr);
        @(negedge Clock);
        cap_next_pc = pc;
        chk({tag, " no_2nd_pulse"}, {15'd0, IssueValid}, 16'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        set;
        logic [15:0] pc0;
        logic [15:0] instr;
        logic        zero;
        int          wait_c;
        logic        issue;
        logic        ld_en;
        logic [15:0] ld_val;
        logic        off_en;
        logic [8:0]  off;
        logic [15:0] next_pc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 1'b0, 2, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 16'h0011};
        vecs[1]  = '{1'b1, 16'h0020, 16'hD1FE, 1'b1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h1FE, 16'h001E};
        vecs[2]  = '{1'b1, 16'h0020, 16'hD1FE, 1'b0, 1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 16'h0021};
        vecs[3]  = '{1'b1, 16'h0100, 16'hC345, 1'b0, 0, 1'b0, 1'b1, 16'h0345, 1'b0, 9'h000, 16'h0345};
        vecs[4]  = '{1'b1, 16'h0005, 16'hE100, 1'b0, 1, 1'b0, 1'b1, 16'h0100, 1'b0, 9'h000, 16'h0100};
        vecs[5]  = '{1'b0, 16'h0000, 16'hF000, 1'b0, 0, 1'b0, 1'b1, 16'h0006, 1'b0, 9'h000, 16'h0006};
        vecs[6]  = '{1'b1, 16'hFFFF, 16'hD005, 1'b1, 3, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h005, 16'h0004};
        vecs[7]  = '{1'b1, 16'h0040, 16'hB001, 1'b1, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 16'h0041};
        vecs[8]  = '{1'b1, 16'h7FFF, 16'hEFFF, 1'b0, 0, 1'b0, 1'b1, 16'h0FFF, 1'b0, 9'h000, 16'h0FFF};
        vecs[9]  = '{1'b0, 16'h0000, 16'hF123, 1'b0, 2, 1'b0, 1'b1, 16'h8000, 1'b0, 9'h000, 16'h8000};
        vecs[10] = '{1'b1, 16'h0030, 16'h0000, 1'b0, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 16'h0031};

        Reset      = 1'b1;
        InstrValid = 1'b0;
        InstrData  = 16'h0000;
        Zero       = 1'b0;
        Stall      = 1'b0;
        pc_set_en  = 1'b1;
        pc_set_val = 16'h0000;
        @(negedge Clock);
        @(negedge Clock);
        chk("rst req", {15'd0, InstrReq}, 16'd1);
        chk("rst issue", {15'd0, IssueValid}, 16'd0);
        chk("rst err", {15'd0, StackError}, 16'd0);
        chk("rst instr", IssueInstr, 16'h0000);
        chk("rst le", {15'd0, LoadEnable}, 16'd1);
        Reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_instr(vecs[i].set, vecs[i].pc0, vecs[i].instr, vecs[i].zero, vecs[i].wait_c, 0,
                      tag);
            chk({tag, " issue"}, {15'd0, cap_issue}, {15'd0, vecs[i].issue});
            chk({tag, " ld_en"}, {15'd0, cap_ld_en}, {15'd0, vecs[i].ld_en});
            if (vecs[i].ld_en) chk({tag, " ld_val"}, cap_ld_val, vecs[i].ld_val);
            chk({tag, " off_en"}, {15'd0, cap_off_en}, {15'd0, vecs[i].off_en});
            if (vecs[i].off_en) chk({tag, " off"}, {7'd0, cap_off}, {7'd0, vecs[i].off});
            chk({tag, " next_pc"}, cap_next_pc, vecs[i].next_pc);
            chk({tag, " err"}, {15'd0, StackError}, 16'd0);
        end

        // Three stalled cycles, then exactly one issue pulse.
        run_instr(1'b1, 16'h0050, 16'h2222, 1'b0, 1, 3, "stall");
        chk("stall issue", {15'd0, cap_issue}, 16'd1);
        chk("stall next_pc", cap_next_pc, 16'h0051);

        // RET on an empty stack right after reset.
        do_reset();
        chk("ret_empty pre_err", {15'd0, StackError}, 16'd0);
        run_instr(1'b1, 16'h0060, 16'hF000, 1'b0, 0, 0, "ret_empty");
        chk("ret_empty ld_en", {15'd0, cap_ld_en}, 16'd0);
        chk("ret_empty off_en", {15'd0, cap_off_en}, 16'd0);
        chk("ret_empty next_pc", cap_next_pc, 16'h0061);
        chk("ret_empty err", {15'd0, StackError}, 16'd1);
        run_instr(1'b1, 16'h0070, 16'h3000, 1'b0, 0, 0, "sticky");
        chk("sticky issue", {15'd0, cap_issue}, 16'd1);
        chk("sticky err", {15'd0, StackError}, 16'd1);

        // Nine nested calls overflow an eight-entry stack.
        do_reset();
        chk("ovf pre_err", {15'd0, StackError}, 16'd0);
        for (int i = 0; i < 9; i++) begin
            string tag;
            logic [15:0] tgt;
            tag = $sformatf("call%0d", i);
            tgt = 16'h0300 + 16'(i * 16);
            run_instr(1'b1, 16'h0200 + 16'(i), 16'hE000 | tgt, 1'b0, 0, 0, tag);
            chk({tag, " ld_en"}, {15'd0, cap_ld_en}, 16'd1);
            chk({tag, " ld_val"}, cap_ld_val, tgt);
            chk({tag, " next_pc"}, cap_next_pc, tgt);
            chk({tag, " err"}, {15'd0, StackError}, (i == 8) ? 16'd1 : 16'd0);
        end
        run_instr(1'b0, 16'h0000, 16'hF000, 1'b0, 0, 0, "ovf_ret");
        chk("ovf_ret ld_val", cap_ld_val, 16'h0208);
        chk("ovf_ret next_pc", cap_next_pc, 16'h0208);

        // Reset during S_WAIT; a late InstrValid in S_FETCH must be ignored.
        do_reset();
        pc_set_val = 16'h0090;
        pc_set_en  = 1'b1;
        @(negedge Clock);
        pc_set_en = 1'b0;
        #1;
        chk("rw in_wait", {15'd0, InstrReq}, 16'd0);
        Reset = 1'b1;
        #1;
        chk("rw reset_req", {15'd0, InstrReq}, 16'd1);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("rw refetch_req", {15'd0, InstrReq}, 16'd1);
        chk("rw instr_clr", IssueInstr, 16'h0000);
        InstrValid = 1'b1;
        InstrData  = 16'hC777;
        @(negedge Clock);
        InstrValid = 1'b0;
        #1;
        chk("rw wait_req", {15'd0, InstrReq}, 16'd0);
        hold_chk("rw wait1");
        chk("rw wait1_pc", pc, 16'h0090);
        @(negedge Clock);
        #1;
        hold_chk("rw wait2");
        chk("rw wait2_req", {15'd0, InstrReq}, 16'd0);
        chk("rw ignored", IssueInstr, 16'h0000);
        InstrValid = 1'b1;
        InstrData  = 16'h1111;
        @(negedge Clock);
        InstrValid = 1'b0;
        #1;
        chk("rw issue", {15'd0, IssueValid}, 16'd1);
        chk("rw issue_instr", IssueInstr, 16'h1111);
        chk("rw le", {15'd0, LoadEnable}, 16'd0);
        @(negedge Clock);
        chk("rw next_pc", pc, 16'h0091);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
